mmio_bus_arbiter: RTL and testbench
===================================

// Module: mmio_bus_arbiter
// PURPOSE
//  Shares the single FPro MMIO bus (the mmio_cs/wr/rd/addr/wr_data/rd_data interface into the
//  mmio subsystem) between two masters: m0 = CPU core, m1 = debug/DMA bridge.
//  Round-robin arbitration, one registered bus cycle per transaction, ack/rd_data back to
//  the winner. Optional bus lock lets a master run atomic read-modify-write sequences.
// PARAMETERS
//  ADDR_W     21  MMIO address width (bus carries 21 bits; the slot decoder uses 11 LSBs)
//  LOCK_MAX   8   max transactions one master may run under lock before forced release
//  LOCK_WAIT  16  idle cycles a lock owner may leave the bus unrequested before release
// PORTS
//  clk           in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  m0_req        in   1       m0 transaction request; held with fields until m0_ack
//  m0_wr         in   1       1 = write, 0 = read
//  m0_addr       in   ADDR_W  m0 address
//  m0_wr_data    in   32      m0 write data
//  m0_lock       in   1       m0 keeps the bus after this transaction
//  m0_ack        out  1       one-cycle pulse: m0 transaction complete
//  m0_rd_data    out  32      m0 read data, valid with m0_ack, held until next m0 read ack
//  m1_*          --   --      identical set for master 1
//  mmio_cs       out  1       bus chip select, high exactly one cycle per transaction
//  mmio_wr       out  1       bus write strobe
//  mmio_rd       out  1       bus read strobe
//  mmio_addr     out  ADDR_W  bus address
//  mmio_wr_data  out  32      bus write data
//  mmio_rd_data  in   32      bus read data, combinational from slot in the mmio_cs cycle
//  owner         out  1       index of master currently granted/locked (status only)
// BEHAVIOUR
//  Reset: state IDLE; all acks, mmio_cs/wr/rd 0; mmio_addr, mmio_wr_data, m*_rd_data 0;
//   rr pointer = 0 (m0 first); lock_active 0, lock_cnt 0, wait_cnt 0; owner 0.
//  FSM IDLE -> ISSUE -> RESP -> IDLE; fixed latency: req seen in IDLE at cycle t,
//   mmio_cs at t+1, ack at t+2. Max throughput 1 transaction / 3 cycles.
//  IDLE: lock_active -> only owner considered; else both requests, winner = rr pointer if it
//   requests, otherwise the other. On grant: latch wr/addr/wr_data into bus regs, owner <=
//   winner, rr pointer <= ~winner, go ISSUE. No request: stay IDLE, outputs idle.
//  ISSUE: mmio_cs=1, mmio_wr=wr, mmio_rd=~wr, addr/data from latches; if read, capture
//   mmio_rd_data into owner's rd_data reg at clock edge; go RESP. Strobes are 0 in all other
//   states; addr/data regs hold last value.
//  RESP: owner's ack=1 (other ack 0). Sample owner's m_lock:
//   lock high and lock_cnt+1 < LOCK_MAX -> lock_active=1, lock_cnt++;
//   otherwise lock_active=0, lock_cnt=0 (forced release; rr pointer already points at other).
//   Go IDLE. Master must drop req the cycle after ack or it is treated as a new request.
//  Lock wait: lock_active in IDLE with owner not requesting -> wait_cnt++; at LOCK_WAIT
//   release lock (clear lock_active, lock_cnt, wait_cnt). wait_cnt clears on any grant.
//  Simultaneous req, no lock: rr pointer decides; alternation guaranteed under contention.
//  Write acks leave m*_rd_data unchanged.
//  Reset mid-transaction: next cycle all outputs at reset values; no ack for the aborted
//   transaction; any bus cycle already driven is not repeated.
//  Widths: counters sized $clog2(LOCK_MAX+1), $clog2(LOCK_WAIT+1); no wrap (saturating).
// STRUCTURE
//  Package mmio_arb_pkg: typedef enum logic[1:0] {IDLE, ISSUE, RESP} arb_state_t;
//   typedef struct {wr, addr, wr_data, lock} mmio_req_t; N_MASTER = 2.
//  Sub-module mmio_rr_pick: combinational 2-way round-robin picker (req[1:0], ptr,
//   lock_active, owner -> grant_valid, grant_idx). FSM, latches, counters stay in top.
// TESTING
//  Single m0 write addr 0x0C4, data 0xA5 -> mmio_cs/wr high 1 cycle at t+1, m0_ack at t+2.
//  m1 read, slot returns 0x1234_5678 -> m1_ack at t+2, m1_rd_data=0x12345678, held after.
//  Both req continuously, no lock -> grants alternate m0,m1,m0,m1; acks never overlap.
//  m0_lock held, both req, LOCK_MAX=8 -> 8 consecutive m0 transactions, then m1 granted.
//  m0 locks then idles -> m1 blocked 16 cycles, granted in cycle after lock release.
//  Reset asserted during ISSUE -> no ack, next cycle strobes 0, state IDLE, rr ptr 0.

Source files
------------

// File: rtl/mmio_bus_arbiter_pkg.sv
// Shared types and constants for the two-master MMIO bus arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mmio_arb_pkg;

  localparam int N_MASTER    = 2;
  localparam int MMIO_ADDR_W = 21;
  localparam int MMIO_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  // One master's transaction request as seen by the arbiter.
  typedef struct packed {
    logic                   wr;
    logic [MMIO_ADDR_W-1:0] addr;
    logic [MMIO_DATA_W-1:0] wr_data;
    logic                   lock;
  } mmio_req_t;

  // A lock may be renewed only while the owner still has budget left.
  function automatic logic lock_extend(input int cnt, input int max_cnt);
    return (cnt + 1) < max_cnt;
  endfunction

endpackage

// File: rtl/mmio_bus_arbiter_if.sv
// Bundle of both master request/response links plus the shared MMIO bus.
// Latency: n/a (wiring only).
// Backpressure: masters hold req and fields until their one-cycle ack.
interface mmio_bus_arbiter_if
  import mmio_arb_pkg::*;
#(
  parameter int ADDR_W = MMIO_ADDR_W
);
  logic              m0_req;
  logic              m0_wr;
  logic [ADDR_W-1:0] m0_addr;
  logic [31:0]       m0_wr_data;
  logic              m0_lock;
  logic              m0_ack;
  logic [31:0]       m0_rd_data;

  logic              m1_req;
  logic              m1_wr;
  logic [ADDR_W-1:0] m1_addr;
  logic [31:0]       m1_wr_data;
  logic              m1_lock;
  logic              m1_ack;
  logic [31:0]       m1_rd_data;

  logic              mmio_cs;
  logic              mmio_wr;
  logic              mmio_rd;
  logic [ADDR_W-1:0] mmio_addr;
  logic [31:0]       mmio_wr_data;
  logic [31:0]       mmio_rd_data;

  logic              owner;

  // Arbiter side: serves the masters, drives the MMIO bus.
  modport slave (
    input  m0_req, m0_wr, m0_addr, m0_wr_data, m0_lock,
    output m0_ack, m0_rd_data,
    input  m1_req, m1_wr, m1_addr, m1_wr_data, m1_lock,
    output m1_ack, m1_rd_data,
    output mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    input  mmio_rd_data,
    output owner
  );

  // Environment side: the two masters and the MMIO slot decoder.
  modport master (
    output m0_req, m0_wr, m0_addr, m0_wr_data, m0_lock,
    input  m0_ack, m0_rd_data,
    output m1_req, m1_wr, m1_addr, m1_wr_data, m1_lock,
    input  m1_ack, m1_rd_data,
    input  mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data,
    output mmio_rd_data,
    input  owner
  );

endinterface

// File: rtl/mmio_rr_pick.sv
// Two-way round-robin picker with lock override.
// Latency: combinational.
// Backpressure: none; a held lock hides the non-owner's request entirely.
module mmio_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       lock_active,
  input  logic       owner,
  output logic       grant_valid,
  output logic       grant_idx
);

  // Locked: only the owner may win. Otherwise the pointer side has priority.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr;
    if (lock_active) begin
      grant_valid = req[owner];
      grant_idx   = owner;
    end else if (req[ptr]) begin
      grant_valid = 1'b1;
      grant_idx   = ptr;
    end else if (req[~ptr]) begin
      grant_valid = 1'b1;
      grant_idx   = ~ptr;
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Shares one MMIO bus between two masters, round-robin with optional bounded lock.
// Latency: request sampled in IDLE at t -> mmio_cs at t+1 -> ack at t+2; 1 txn / 3 cycles.
// Backpressure: a master waits with req held until ack; the loser waits for the next IDLE.
module mmio_bus_arbiter
  import mmio_arb_pkg::*;
#(
  parameter int ADDR_W    = MMIO_ADDR_W,
  parameter int LOCK_MAX  = 8,
  parameter int LOCK_WAIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  mmio_bus_arbiter_if.slave   bus
);

  localparam int LC_W = $clog2(LOCK_MAX + 1);
  localparam int WC_W = $clog2(LOCK_WAIT + 1);

  arb_state_t        state;
  logic              rr_ptr;
  logic              owner_q;
  logic              lock_active;
  logic [LC_W-1:0]   lock_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic [1:0]        ack_q;
  logic [31:0]       rdata_q [N_MASTER];
  logic              cs_q;
  logic              wr_q;
  logic              rd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  mmio_req_t         mreq [N_MASTER];
  logic [1:0]        req_vec;
  logic              grant_valid;
  logic              grant_idx;

  // Gather each master's live request fields into a common shape.
  always_comb begin
    mreq[0] = '{wr: bus.m0_wr, addr: MMIO_ADDR_W'(bus.m0_addr),
                wr_data: bus.m0_wr_data, lock: bus.m0_lock};
    mreq[1] = '{wr: bus.m1_wr, addr: MMIO_ADDR_W'(bus.m1_addr),
                wr_data: bus.m1_wr_data, lock: bus.m1_lock};
    req_vec = {bus.m1_req, bus.m0_req};
  end

  mmio_rr_pick u_pick (
    .req         (req_vec),
    .ptr         (rr_ptr),
    .lock_active (lock_active),
    .owner       (owner_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Arbitration FSM: grant, drive one bus cycle, acknowledge, then decide the lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      owner_q     <= 1'b0;
      lock_active <= 1'b0;
      lock_cnt    <= '0;
      wait_cnt    <= '0;
      ack_q       <= '0;
      cs_q        <= 1'b0;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q[0]  <= '0;
      rdata_q[1]  <= '0;
    end else begin
      // Strobes and acks are single-cycle pulses unless re-asserted below.
      cs_q  <= 1'b0;
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      ack_q <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            cs_q     <= 1'b1;
            wr_q     <= mreq[grant_idx].wr;
            rd_q     <= ~mreq[grant_idx].wr;
            addr_q   <= ADDR_W'(mreq[grant_idx].addr);
            wdata_q  <= mreq[grant_idx].wr_data;
            owner_q  <= grant_idx;
            rr_ptr   <= ~grant_idx;
            wait_cnt <= '0;
            state    <= ISSUE;
          end else if (lock_active && !req_vec[owner_q]) begin
            // Owner sat on the lock without using the bus: give it up eventually.
            if (int'(wait_cnt) + 1 >= LOCK_WAIT) begin
              lock_active <= 1'b0;
              lock_cnt    <= '0;
              wait_cnt    <= '0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        ISSUE: begin
          if (rd_q) begin
            rdata_q[owner_q] <= bus.mmio_rd_data;
          end
          ack_q[owner_q] <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          // rr_ptr already points away from the owner, so a forced release hands over.
          if (mreq[owner_q].lock && lock_extend(int'(lock_cnt), LOCK_MAX)) begin
            lock_active <= 1'b1;
            lock_cnt    <= lock_cnt + 1'b1;
          end else begin
            lock_active <= 1'b0;
            lock_cnt    <= '0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m0_ack       = ack_q[0];
  assign bus.m1_ack       = ack_q[1];
  assign bus.m0_rd_data   = rdata_q[0];
  assign bus.m1_rd_data   = rdata_q[1];
  assign bus.mmio_cs      = cs_q;
  assign bus.mmio_wr      = wr_q;
  assign bus.mmio_rd      = rd_q;
  assign bus.mmio_addr    = addr_q;
  assign bus.mmio_wr_data = wdata_q;
  assign bus.owner        = owner_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for the MMIO bus arbiter: directed table, multi-cycle sequences, random traffic.
// Latency: expects cs at t+1 and ack at t+2 after a request is seen idle at t.
// Backpressure: bench masters hold requests until ack and drop them in the ack cycle.
module tb_mmio_bus_arbiter;

  localparam int AW    = 21;
  localparam int LMAX  = 8;
  localparam int LWAIT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mmio_bus_arbiter_if #(.ADDR_W(AW)) bus ();

  mmio_bus_arbiter #(.ADDR_W(AW), .LOCK_MAX(LMAX), .LOCK_WAIT(LWAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Slot decoder stand-in: fixed override or an address hash.
  logic        ovr_en  = 1'b1;
  logic [31:0] ovr_val = 32'h0;

  function automatic logic [31:0] slot_fn(input logic [AW-1:0] a);
    return {a[10:0], 21'h0} ^ {11'h0, a} ^ 32'h9E37_79B9;
  endfunction

  assign bus.mmio_rd_data = ovr_en ? ovr_val : slot_fn(bus.mmio_addr);

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Bench master state.
  logic          mreq  [2];
  logic          mwr   [2];
  logic [AW-1:0] maddr [2];
  logic [31:0]   mdat  [2];
  logic          mlock [2];
  int            mode  [2];   // 0 idle, 1 random, 2 always, 3 one-shot
  int            lmode [2];   // 0 never lock, 1 always lock, 2 random lock

  task automatic drive_bus();
    bus.m0_req = mreq[0]; bus.m0_wr = mwr[0]; bus.m0_addr = maddr[0];
    bus.m0_wr_data = mdat[0]; bus.m0_lock = mlock[0];
    bus.m1_req = mreq[1]; bus.m1_wr = mwr[1]; bus.m1_addr = maddr[1];
    bus.m1_wr_data = mdat[1]; bus.m1_lock = mlock[1];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: transactions scheduled on absolute cycle numbers.
  int            cs_at, ack_at, free_at, who, ptr, lock_own, lock_n, idle_n;
  logic          lock_on;
  logic          e_wr;
  logic [AW-1:0] e_addr;
  logic [31:0]   e_wdat, e_rdv;
  logic [31:0]   e_rd [2];
  logic          e_owner;
  int            ack_who[$], ack_cyc[$], cs_own[$], cs_cyc[$];

  task automatic model_reset();
    cs_at = -10; ack_at = -10; free_at = 0; who = 0; ptr = 0;
    lock_on = 1'b0; lock_own = 0; lock_n = 0; idle_n = 0;
    e_rd[0] = '0; e_rd[1] = '0; e_owner = 1'b0;
    e_wr = 1'b0; e_addr = '0; e_wdat = '0; e_rdv = '0;
    ack_who.delete(); ack_cyc.delete(); cs_own.delete(); cs_cyc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      mreq[k] = 1'b0; mwr[k] = 1'b0; maddr[k] = '0; mdat[k] = '0; mlock[k] = 1'b0;
    end
    drive_bus();
    repeat (2) tick();
    reset = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  task automatic check_outputs();
    logic ecs, ea0, ea1;
    ecs = (cyc == cs_at);
    ea0 = (cyc == ack_at) && (who == 0);
    ea1 = (cyc == ack_at) && (who == 1);
    if (cyc == ack_at && !e_wr) e_rd[who] = e_rdv;
    chk("ctl", {bus.mmio_cs, bus.mmio_wr, bus.mmio_rd, bus.m0_ack, bus.m1_ack, bus.owner},
               {ecs, ecs & e_wr, ecs & ~e_wr, ea0, ea1, e_owner});
    if (ecs) begin
      chk("addr", bus.mmio_addr, e_addr);
      chk("wdata", bus.mmio_wr_data, e_wdat);
    end
    chk("rd0", bus.m0_rd_data, e_rd[0]);
    chk("rd1", bus.m1_rd_data, e_rd[1]);
    if (bus.m0_ack) begin ack_who.push_back(0); ack_cyc.push_back(cyc); end
    if (bus.m1_ack) begin ack_who.push_back(1); ack_cyc.push_back(cyc); end
    if (bus.mmio_cs) begin cs_own.push_back(int'(bus.owner)); cs_cyc.push_back(cyc); end
  endtask

  task automatic masters_drive();
    for (int k = 0; k < 2; k++) begin
      if (cyc == ack_at && who == k) begin
        mreq[k] = 1'b0;
      end else if (!mreq[k] && (mode[k] == 2 || mode[k] == 3 ||
                                (mode[k] == 1 && $urandom_range(0, 2) == 0))) begin
        mreq[k]  = 1'b1;
        mwr[k]   = 1'($urandom);
        maddr[k] = AW'($urandom);
        mdat[k]  = $urandom;
        mlock[k] = (lmode[k] == 1) ? 1'b1 :
                   (lmode[k] == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        if (mode[k] == 3) mode[k] = 0;
      end
    end
    drive_bus();
  endtask

  task automatic model_decide();
    int w;
    w = -1;
    if (cyc == ack_at) begin
      if (mlock[who] && lock_n + 1 < LMAX) begin
        lock_on = 1'b1; lock_n++; lock_own = who;
      end else begin
        lock_on = 1'b0; lock_n = 0;
      end
    end
    if (cyc >= free_at) begin
      if (lock_on) begin
        if (mreq[lock_own]) w = lock_own;
        else begin
          idle_n++;
          if (idle_n >= LWAIT) begin lock_on = 1'b0; lock_n = 0; idle_n = 0; end
        end
      end else if (mreq[ptr]) w = ptr;
      else if (mreq[1-ptr]) w = 1 - ptr;
      if (w >= 0) begin
        who = w; ptr = 1 - w; e_owner = w[0]; idle_n = 0;
        cs_at = cyc + 1; ack_at = cyc + 2; free_at = cyc + 3;
        e_wr = mwr[w]; e_addr = maddr[w]; e_wdat = mdat[w]; e_rdv = slot_fn(maddr[w]);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      tick();
      cyc++;
      check_outputs();
      masters_drive();
      model_decide();
    end
  endtask

  function automatic int first_of(input int q_who[$], input int q_cyc[$], input int k);
    for (int i = 0; i < q_who.size(); i++)
      if (q_who[i] == k) return q_cyc[i];
    return -1000;
  endfunction

  // Isolated single transactions with hand-computed expectations.
  typedef struct {
    logic          m;
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   slot;
    logic [31:0]   exp_rd;
  } vec_t;

  vec_t tbl [6];

  initial begin
    tbl[0] = '{m: 1'b0, wr: 1'b1, addr: 21'h0000C4, wdata: 32'h0000_00A5, slot: 32'h0, exp_rd: 32'h0};
    tbl[1] = '{m: 1'b1, wr: 1'b0, addr: 21'h000100, wdata: 32'h55, slot: 32'h1234_5678, exp_rd: 32'h1234_5678};
    tbl[2] = '{m: 1'b0, wr: 1'b0, addr: 21'h0007FF, wdata: 32'h55, slot: 32'hDEAD_BEEF, exp_rd: 32'hDEAD_BEEF};
    tbl[3] = '{m: 1'b1, wr: 1'b1, addr: 21'h1FFFFF, wdata: 32'hFFFF_FFFF, slot: 32'hAAAA_AAAA, exp_rd: 32'h1234_5678};
    tbl[4] = '{m: 1'b0, wr: 1'b1, addr: 21'h000000, wdata: 32'h0, slot: 32'h5555_5555, exp_rd: 32'hDEAD_BEEF};
    tbl[5] = '{m: 1'b1, wr: 1'b0, addr: 21'h155555, wdata: 32'h77, slot: 32'h0, exp_rd: 32'h0};

    mode[0] = 0; mode[1] = 0; lmode[0] = 0; lmode[1] = 0;
    do_reset();

    // Reset state.
    chk("rst_ctl", {bus.mmio_cs, bus.mmio_wr, bus.mmio_rd, bus.m0_ack, bus.m1_ack, bus.owner}, 6'b0);
    chk("rst_addr", bus.mmio_addr, '0);
    chk("rst_wdata", bus.mmio_wr_data, '0);
    chk("rst_rd0", bus.m0_rd_data, '0);
    chk("rst_rd1", bus.m1_rd_data, '0);

    // Table-driven single transactions.
    ovr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      int m;
      m = int'(tbl[i].m);
      ovr_val  = tbl[i].slot;
      mreq[m]  = 1'b1; mwr[m] = tbl[i].wr; maddr[m] = tbl[i].addr;
      mdat[m]  = tbl[i].wdata; mlock[m] = 1'b0;
      drive_bus();
      tick();
      chk("tbl_issue", {bus.mmio_cs, bus.mmio_wr, bus.mmio_rd, bus.m1_ack, bus.m0_ack},
                       {1'b1, tbl[i].wr, ~tbl[i].wr, 2'b00});
      chk("tbl_addr", bus.mmio_addr, tbl[i].addr);
      chk("tbl_wdata", bus.mmio_wr_data, tbl[i].wdata);
      tick();
      chk("tbl_ack", {bus.mmio_cs, bus.m1_ack, bus.m0_ack, bus.owner},
                     {1'b0, tbl[i].m, ~tbl[i].m, tbl[i].m});
      chk("tbl_rd", tbl[i].m ? bus.m1_rd_data : bus.m0_rd_data, tbl[i].exp_rd);
      mreq[m] = 1'b0;
      drive_bus();
      tick();
      chk("tbl_post", {bus.mmio_cs, bus.m1_ack, bus.m0_ack}, 3'b000);
      chk("tbl_hold", tbl[i].m ? bus.m1_rd_data : bus.m0_rd_data, tbl[i].exp_rd);
    end
    ovr_en = 1'b0;

    // Reset during ISSUE: no ack, outputs and pointer back to reset values.
    do_reset();
    mreq[0] = 1'b1; mwr[0] = 1'b1; maddr[0] = 21'h10; mdat[0] = 32'h1;
    drive_bus();
    tick(); tick();
    mreq[0] = 1'b0; drive_bus();
    tick();
    mreq[0] = 1'b1; mwr[0] = 1'b0; maddr[0] = 21'h20; drive_bus();
    tick();
    chk("rst_pre_cs", bus.mmio_cs, 1'b1);
    reset = 1'b1;
    tick();
    chk("rst_mid_ctl", {bus.mmio_cs, bus.mmio_wr, bus.mmio_rd, bus.m0_ack, bus.m1_ack, bus.owner}, 6'b0);
    chk("rst_mid_addr", bus.mmio_addr, '0);
    chk("rst_mid_wdata", bus.mmio_wr_data, '0);
    chk("rst_mid_rd0", bus.m0_rd_data, '0);
    reset = 1'b0;
    mreq[0] = 1'b0; drive_bus();
    tick();
    chk("rst_no_ack", {bus.m0_ack, bus.mmio_cs}, 2'b00);
    mreq[0] = 1'b1; mreq[1] = 1'b1; mwr[0] = 1'b0; mwr[1] = 1'b0; drive_bus();
    tick();
    chk("rst_ptr", {bus.mmio_cs, bus.owner}, 2'b10);
    mreq[0] = 1'b0; mreq[1] = 1'b0; drive_bus();
    tick(); tick();

    // Contention without lock: strict alternation.
    do_reset();
    mode[0] = 2; mode[1] = 2; lmode[0] = 0; lmode[1] = 0;
    run(20);
    for (int i = 0; i < 4; i++)
      chk("alt_seq", (i < ack_who.size()) ? ack_who[i] : 9, i % 2);

    // m0 holds lock under contention: LOCK_MAX back-to-back, then m1.
    do_reset();
    mode[0] = 2; mode[1] = 2; lmode[0] = 1; lmode[1] = 0;
    run(40);
    for (int i = 0; i < LMAX + 1; i++)
      chk("lockmax_seq", (i < ack_who.size()) ? ack_who[i] : 9, (i < LMAX) ? 0 : 1);

    // m0 locks then goes quiet: m1 waits out LOCK_WAIT idle cycles.
    do_reset();
    mode[0] = 3; mode[1] = 2; lmode[0] = 1; lmode[1] = 0;
    run(30);
    chk("lockwait_gap", first_of(cs_own, cs_cyc, 1) - first_of(ack_who, ack_cyc, 0), LWAIT + 2);

    // Random traffic with random locks against the model.
    do_reset();
    mode[0] = 1; mode[1] = 1; lmode[0] = 2; lmode[1] = 2;
    run(3000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
